// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiply-accumulate datapath: default widths of
// the product, accumulator and beat counter, and the accumulator state
// enumeration.
// -----------------------------------------------------------------------------
package mult_pkg;

  // Product width delivered by the upstream 36x36 multiplier.
  localparam int unsigned PROD_W_DEF = 32'd72;
  // Accumulator width; must be at least the product width.
  localparam int unsigned ACC_W_DEF  = 32'd80;
  // Beat-counter width.
  localparam int unsigned CNT_W_DEF  = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_accum.sv
// -----------------------------------------------------------------------------
// mult_accum
// Sums a group of unsigned products (one beat per cycle, bubbles allowed) and
// presents the group result until the downstream side takes it.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_prod    in   PROD_W  unsigned product
//   in_valid   in   in_prod/in_last valid
//   in_last    in   final beat of a group
//   in_ready   out  a beat is accepted this cycle when in_valid is also high
//   out_sum    out  ACC_W   group sum modulo 2^ACC_W
//   out_count  out  CNT_W   number of beats in the group, saturating
//   out_ovf    out  sticky carry-out of the accumulator within the group
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
// -----------------------------------------------------------------------------
module mult_accum
  import mult_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_r;
  state_t             state_nx;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   acc_nx;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nx;
  logic               ovf_r;
  logic               ovf_nx;
  logic               valid_r;
  logic               valid_nx;
  logic               accept_s;
  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W:0]     sum_ext_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  // Ready is forced low during reset so no beat is counted as taken then.
  assign in_ready   = (!rst) && (state_r != ST_HOLD);
  assign accept_s   = in_valid && in_ready;
  assign prod_ext_s = ACC_W'(in_prod);
  // One extra bit on the adder captures the carry-out for the sticky flag.
  assign sum_ext_s  = {1'b0, acc_r} + {1'b0, prod_ext_s};
  assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

  // Next-state and datapath update logic.
  always_comb begin
    state_nx = state_r;
    acc_nx   = acc_r;
    cnt_nx   = cnt_r;
    ovf_nx   = ovf_r;
    valid_nx = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          acc_nx   = prod_ext_s;
          cnt_nx   = CNT_ONE;
          ovf_nx   = 1'b0;
          state_nx = in_last ? ST_HOLD : ST_ACCUM;
          valid_nx = in_last;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_nx   = sum_ext_s[ACC_W-1:0];
          cnt_nx   = cnt_inc_s;
          ovf_nx   = ovf_r | sum_ext_s[ACC_W];
          state_nx = in_last ? ST_HOLD : ST_ACCUM;
          valid_nx = in_last;
        end else begin
          state_nx = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (valid_r && out_ready) begin
          state_nx = ST_IDLE;
          valid_nx = 1'b0;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      acc_r   <= acc_nx;
      cnt_r   <= cnt_nx;
      ovf_r   <= ovf_nx;
      valid_r <= valid_nx;
    end
  end

  assign out_sum   = acc_r;
  assign out_count = cnt_r;
  assign out_ovf   = ovf_r;
  assign out_valid = valid_r;

endmodule

// File: tb/tb_mult_accum.sv
// -----------------------------------------------------------------------------
// tb_mult_accum
// Directed bench for mult_accum: a per-cycle vector table for the basic
// sequences plus hand-written multi-cycle corner cases. A second instance
// with CNT_W=4 covers counter saturation.
// -----------------------------------------------------------------------------
module tb_mult_accum;

  localparam int PW = 72;
  localparam int AW = 80;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [PW-1:0] in_prod;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;
  logic          out_valid;
  logic          out_ready;

  logic [PW-1:0] s_prod;
  logic          s_valid;
  logic          s_last;
  logic          s_in_ready;
  logic [AW-1:0] s_sum;
  logic [3:0]    s_count;
  logic          s_ovf;
  logic          s_out_valid;
  logic          s_out_ready;

  int n_checks;
  int n_errors;

  mult_accum #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_prod(in_prod), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mult_accum #(.PROD_W(PW), .ACC_W(AW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_prod(s_prod), .in_valid(s_valid),
    .in_last(s_last), .in_ready(s_in_ready), .out_sum(s_sum),
    .out_count(s_count), .out_ovf(s_ovf), .out_valid(s_out_valid),
    .out_ready(s_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] prod;
    logic          last;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic [AW-1:0] exp_sum;
    logic [CW-1:0] exp_cnt;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic ir, input logic ov,
                          input logic [AW-1:0] sm, input logic [CW-1:0] cn, input logic of);
    chk({tag, ".in_ready"}, AW'(in_ready), AW'(ir));
    chk({tag, ".out_valid"}, AW'(out_valid), AW'(ov));
    chk({tag, ".out_sum"}, out_sum, sm);
    chk({tag, ".out_count"}, AW'(out_count), AW'(cn));
    chk({tag, ".out_ovf"}, AW'(out_ovf), AW'(of));
  endtask

  // Inputs change after the falling edge; sampling happens 1 time unit later.
  task automatic drive(input logic v, input logic [PW-1:0] p, input logic l, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  logic [PW-1:0] ones;
  logic [AW-1:0] big;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_prod     = '0;
    in_last     = 1'b0;
    out_ready   = 1'b0;
    s_valid     = 1'b0;
    s_prod      = '0;
    s_last      = 1'b0;
    s_out_ready = 1'b0;
    ones        = {PW{1'b1}};
    big         = (AW'(1) << 72) + AW'(11);

    // valid, prod, last, ordy | in_ready, out_valid, sum, count, ovf
    vecs[0] = '{1'b1, PW'(1), 1'b1, 1'b0, 1'b1, 1'b0, AW'(0),  CW'(0), 1'b0};
    vecs[1] = '{1'b0, PW'(0), 1'b0, 1'b1, 1'b0, 1'b1, AW'(1),  CW'(1), 1'b0};
    vecs[2] = '{1'b1, PW'(5), 1'b0, 1'b0, 1'b1, 1'b0, AW'(1),  CW'(1), 1'b0};
    vecs[3] = '{1'b0, PW'(0), 1'b0, 1'b0, 1'b1, 1'b0, AW'(5),  CW'(1), 1'b0};
    vecs[4] = '{1'b1, PW'(7), 1'b0, 1'b0, 1'b1, 1'b0, AW'(5),  CW'(1), 1'b0};
    vecs[5] = '{1'b1, ones,   1'b1, 1'b0, 1'b1, 1'b0, AW'(12), CW'(2), 1'b0};
    vecs[6] = '{1'b0, PW'(0), 1'b0, 1'b1, 1'b0, 1'b1, big,     CW'(3), 1'b0};
    vecs[7] = '{1'b0, PW'(0), 1'b0, 1'b0, 1'b1, 1'b0, big,     CW'(3), 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 1'b0, 1'b0, AW'(0), CW'(0), 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: single beat, then 5,7,2^72-1 with a bubble
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].valid, vecs[i].prod, vecs[i].last, vecs[i].ordy);
      chk_main($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_ov,
               vecs[i].exp_sum, vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // 257 beats of 2^72-1 wrap the 80-bit accumulator once
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, ones, (i == 256), 1'b0);
    end
    drive(1'b0, PW'(0), 1'b0, 1'b0);
    chk_main("wrap257", 1'b0, 1'b1, (AW'(1) << 72) - AW'(257), CW'(257), 1'b1);
    drive(1'b0, PW'(0), 1'b0, 1'b1);
    drive(1'b0, PW'(0), 1'b0, 1'b0);
    chk("wrap257.release", AW'(out_valid), AW'(0));

    // Back-pressure in HOLD with in_valid held high
    drive(1'b1, PW'(9), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, PW'(100), 1'b1, 1'b0);
      chk_main($sformatf("stall%0d", i), 1'b0, 1'b1, AW'(9), CW'(1), 1'b0);
    end
    drive(1'b0, PW'(0), 1'b0, 1'b1);
    drive(1'b0, PW'(0), 1'b0, 1'b0);
    chk_main("stall.after", 1'b1, 1'b0, AW'(9), CW'(1), 1'b0);

    // Reset mid-group discards the partial sum
    drive(1'b1, PW'(10), 1'b0, 1'b0);
    drive(1'b1, PW'(20), 1'b0, 1'b0);
    drive(1'b0, PW'(0), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", AW'(in_ready), AW'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, PW'(3), 1'b1, 1'b0);
    drive(1'b0, PW'(0), 1'b0, 1'b0);
    chk_main("midrst.after", 1'b0, 1'b1, AW'(3), CW'(1), 1'b0);

    // Reset while holding a result drops it without a handshake
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_main("holdrst", 1'b1, 1'b0, AW'(0), CW'(0), 1'b0);

    // Saturating 4-bit counter: 20 beats of 1
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_prod  = PW'(1);
      s_last  = (i == 19);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("sat.out_valid", AW'(s_out_valid), AW'(1));
    chk("sat.out_sum", s_sum, AW'(20));
    chk("sat.out_count", AW'(s_count), AW'(15));
    chk("sat.out_ovf", AW'(s_ovf), AW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
